// File: rtl/ternary_weight_loader_pkg.sv
// Shared types and constants for the ternary weight loader and the multiplier it feeds.
package ternary_weight_loader_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StReady, StRun} state_e;

  localparam logic [1:0] TERN_ZERO = 2'b00;
  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b11;
  localparam logic [1:0] TERN_BAD  = 2'b10;

  localparam int unsigned DEF_IN_LEN    = 16;
  localparam int unsigned DEF_OUT_LEN   = 8;
  localparam int unsigned DEF_BIT_WIDTH = 8;

endpackage

// File: rtl/ternary_row_sanitize.sv
// Combinational clean-up of one weight row: the illegal 2'b10 code is forced to zero and
// flagged so the caller can record it.
module ternary_row_sanitize
  import ternary_weight_loader_pkg::*;
#(
  parameter int unsigned OUT_LEN = DEF_OUT_LEN
) (
  input  logic [2*OUT_LEN-1:0] row_in,
  output logic [2*OUT_LEN-1:0] row_out,
  output logic                 any_bad
);

  always_comb begin
    row_out = row_in;
    any_bad = 1'b0;
    for (int i = 0; i < OUT_LEN; i++) begin
      if (row_in[2*i +: 2] == TERN_BAD) begin
        row_out[2*i +: 2] = TERN_ZERO;
        any_bad           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ternary_weight_loader.sv
// Loads the ternary weight matrix one row per beat, then streams registered activation
// pairs to the multiplier while holding the weights stable.
module ternary_weight_loader
  import ternary_weight_loader_pkg::*;
#(
  parameter int unsigned IN_LEN    = DEF_IN_LEN,
  parameter int unsigned OUT_LEN   = DEF_OUT_LEN,
  parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_start,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          data_valid,
  input  logic [2*OUT_LEN-1:0]          data_in,
  output logic [2*IN_LEN*OUT_LEN-1:0]   w_out,
  output logic [2*BIT_WIDTH-1:0]        vec_out,
  output logic                          mult_en,
  output logic                          weights_ready,
  output logic                          bad_code,
  output logic [$clog2(IN_LEN)-1:0]     beat_cnt
);

  localparam int unsigned RowW = 2 * OUT_LEN;
  localparam int unsigned CntW = $clog2(IN_LEN);

  state_e                       state_q, state_d;
  logic [2*IN_LEN*OUT_LEN-1:0]  w_q;
  logic [2*BIT_WIDTH-1:0]       vec_q;
  logic                         en_q;
  logic                         bad_q;
  logic [CntW-1:0]              cnt_q;

  logic [RowW-1:0]              row_clean;
  logic                         row_bad;
  logic                         last_beat;

  ternary_row_sanitize #(
    .OUT_LEN (OUT_LEN)
  ) u_sanitize (
    .row_in  (data_in),
    .row_out (row_clean),
    .any_bad (row_bad)
  );

  assign last_beat = (cnt_q == CntW'(IN_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // load_start wins from every state, over both start and stop.
  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StLoad:  if (data_valid && last_beat) state_d = StReady;
        StReady: if (start) state_d = StRun;
        StRun:   if (stop) state_d = StIdle;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    weights_ready = (state_q == StReady) || (state_q == StRun);
  end

  // The restart edge never writes a row; rows not yet rewritten keep their old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= '0;
      vec_q <= '0;
      en_q  <= 1'b0;
      bad_q <= 1'b0;
      cnt_q <= '0;
    end else if (load_start) begin
      cnt_q <= '0;
      bad_q <= 1'b0;
      en_q  <= 1'b0;
      vec_q <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (data_valid) begin
            for (int r = 0; r < IN_LEN; r++) begin
              if (cnt_q == CntW'(r)) w_q[r*RowW +: RowW] <= row_clean;
            end
            bad_q <= bad_q | row_bad;
            cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
          end
        end
        StReady: begin
          if (start) begin
            vec_q <= data_in;
            en_q  <= 1'b1;
          end
        end
        StRun: begin
          if (stop) begin
            vec_q <= '0;
            en_q  <= 1'b0;
          end else begin
            vec_q <= data_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_out    = w_q;
  assign vec_out  = vec_q;
  assign mult_en  = en_q;
  assign bad_code = bad_q;
  assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_ternary_weight_loader.sv
// Directed bench for ternary_weight_loader: load, sanitise, stream, and abort paths.
module tb_ternary_weight_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_start, start, stop, data_valid;
  logic [15:0]  data_in;
  logic [255:0] w_out;
  logic [15:0]  vec_out;
  logic         mult_en, weights_ready, bad_code;
  logic [3:0]   beat_cnt;

  int errors = 0;
  int checks = 0;

  logic [15:0]  rows [16];
  logic [255:0] exp_w;

  always #5 clk = ~clk;

  ternary_weight_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_start    (load_start),
    .start         (start),
    .stop          (stop),
    .data_valid    (data_valid),
    .data_in       (data_in),
    .w_out         (w_out),
    .vec_out       (vec_out),
    .mult_en       (mult_en),
    .weights_ready (weights_ready),
    .bad_code      (bad_code),
    .beat_cnt      (beat_cnt)
  );

  // Inputs change just after a falling edge; outputs are read at the next falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [15:0] clean_row(input logic [15:0] r);
    logic [15:0] o;
    o = r;
    for (int i = 0; i < 8; i++) if (r[2*i +: 2] == 2'b10) o[2*i +: 2] = 2'b00;
    return o;
  endfunction

  task automatic build_exp();
    for (int r = 0; r < 16; r++) exp_w[r*16 +: 16] = clean_row(rows[r]);
  endtask

  task automatic do_load(input bit gaps);
    load_start = 1'b1; data_valid = 1'b0; tick();
    load_start = 1'b0;
    for (int r = 0; r < 16; r++) begin
      data_valid = 1'b1; data_in = rows[r]; tick();
      if (gaps) begin
        checks++;
        if (beat_cnt !== 4'((r + 1) % 16)) begin
          errors++; $display("FAIL gap_cnt_valid r=%0d got %0d want %0d", r, beat_cnt, (r + 1) % 16);
        end
        data_valid = 1'b0; data_in = 16'h8AAA; tick();
        checks++;
        if (beat_cnt !== 4'((r + 1) % 16)) begin
          errors++; $display("FAIL gap_cnt_hold r=%0d got %0d want %0d", r, beat_cnt, (r + 1) % 16);
        end
      end
    end
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_start = 0; start = 0; stop = 0; data_valid = 0; data_in = '0;
    tick(); tick();
    checks++;
    if ({w_out, vec_out, mult_en, weights_ready, bad_code, beat_cnt} !== '0) begin
      errors++; $display("FAIL reset_state got w=%h v=%h en=%b rdy=%b bad=%b cnt=%0d want all zero",
                         w_out, vec_out, mult_en, weights_ready, bad_code, beat_cnt);
    end
    rst_n = 1'b1; tick();
  endtask

  task automatic test_load_basic();
    for (int k = 0; k < 16; k++) rows[k] = k[0] ? 16'hFFFF : 16'h5555;
    build_exp();
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (weights_ready !== 1'b0) begin
        errors++; $display("FAIL ready_early beat=%0d got %b want 0", r, weights_ready);
      end
      data_valid = 1'b1; data_in = rows[r]; tick();
    end
    data_valid = 1'b0;
    checks++;
    if (weights_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_16 got %b want 1", weights_ready);
    end
    checks++;
    if (w_out[31:0] !== 32'hFFFF_5555) begin
      errors++; $display("FAIL rows01 got %h want ffff5555", w_out[31:0]);
    end
    checks++;
    if (w_out !== exp_w || bad_code !== 1'b0 || beat_cnt !== 4'd0) begin
      errors++; $display("FAIL load_basic got w=%h bad=%b cnt=%0d want w=%h bad=0 cnt=0",
                         w_out, bad_code, beat_cnt, exp_w);
    end
  endtask

  task automatic test_load_gaps();
    for (int k = 0; k < 16; k++) rows[k] = k[0] ? 16'h1D47 : 16'h3C0F;
    rows[15] = 16'hF5F5;
    build_exp();
    do_load(1'b1);
    checks++;
    if (w_out !== exp_w || weights_ready !== 1'b1 || w_out[31:16] !== 16'h1D47) begin
      errors++; $display("FAIL load_gaps got w=%h rdy=%b want w=%h rdy=1", w_out, weights_ready, exp_w);
    end
  endtask

  task automatic test_bad_code();
    for (int k = 0; k < 16; k++) rows[k] = 16'h0000;
    rows[3] = 16'h8001;
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      data_valid = 1'b1; data_in = rows[r]; tick();
    end
    checks++;
    if (bad_code !== 1'b1 || w_out[63:48] !== 16'h0001) begin
      errors++; $display("FAIL bad_row3 got bad=%b row3=%h want bad=1 row3=0001", bad_code, w_out[63:48]);
    end
    // Restart with a valid beat on the same edge: nothing written, counter and flag cleared.
    load_start = 1'b1; data_valid = 1'b1; data_in = 16'hFFFF; tick();
    load_start = 1'b0; data_valid = 1'b0;
    checks++;
    if (bad_code !== 1'b0 || beat_cnt !== 4'd0 || w_out[15:0] !== 16'h0000 || w_out[63:48] !== 16'h0001) begin
      errors++; $display("FAIL restart got bad=%b cnt=%0d row0=%h row3=%h want 0 0 0000 0001",
                         bad_code, beat_cnt, w_out[15:0], w_out[63:48]);
    end
  endtask

  task automatic test_run();
    for (int k = 0; k < 16; k++) rows[k] = k[0] ? 16'hFFFF : 16'h5555;
    build_exp();
    do_load(1'b0);
    start = 1'b1; data_in = 16'h0302; tick();
    start = 1'b0;
    checks++;
    if (vec_out !== 16'h0302 || mult_en !== 1'b1 || weights_ready !== 1'b1) begin
      errors++; $display("FAIL run_first got v=%h en=%b rdy=%b want 0302 1 1", vec_out, mult_en, weights_ready);
    end
    data_valid = 1'b0; data_in = 16'h0504; tick();
    checks++;
    if (vec_out !== 16'h0504 || mult_en !== 1'b1 || w_out !== exp_w) begin
      errors++; $display("FAIL run_second got v=%h en=%b want 0504 1 (w stable)", vec_out, mult_en);
    end
    stop = 1'b1; data_in = 16'h0706; tick(); stop = 1'b0;
    checks++;
    if (vec_out !== 16'h0000 || mult_en !== 1'b0 || weights_ready !== 1'b0) begin
      errors++; $display("FAIL run_stop got v=%h en=%b rdy=%b want 0000 0 0", vec_out, mult_en, weights_ready);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (mult_en !== 1'b0 || weights_ready !== 1'b0) begin
      errors++; $display("FAIL idle_start got en=%b rdy=%b want 0 0", mult_en, weights_ready);
    end
  endtask

  task automatic test_priority();
    do_load(1'b0);
    load_start = 1'b1; start = 1'b1; tick(); load_start = 1'b0; start = 1'b0;
    checks++;
    if (mult_en !== 1'b0 || weights_ready !== 1'b0 || beat_cnt !== 4'd0) begin
      errors++; $display("FAIL ready_prio got en=%b rdy=%b cnt=%0d want 0 0 0", mult_en, weights_ready, beat_cnt);
    end
    do_load(1'b0);
    start = 1'b1; data_in = 16'h1111; tick(); start = 1'b0;
    stop = 1'b1; load_start = 1'b1; tick(); stop = 1'b0; load_start = 1'b0;
    checks++;
    if (mult_en !== 1'b0 || weights_ready !== 1'b0 || beat_cnt !== 4'd0) begin
      errors++; $display("FAIL run_prio got en=%b rdy=%b cnt=%0d want 0 0 0", mult_en, weights_ready, beat_cnt);
    end
    data_valid = 1'b1; data_in = 16'h5555; tick(); data_valid = 1'b0;
    checks++;
    if (beat_cnt !== 4'd1) begin
      errors++; $display("FAIL run_prio_load got cnt=%0d want 1", beat_cnt);
    end
  endtask

  task automatic test_reset_mid_load();
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int r = 0; r < 7; r++) begin
      data_valid = 1'b1; data_in = 16'hFFFF; tick();
    end
    data_valid = 1'b0;
    rst_n = 1'b0; #1;
    checks++;
    if (w_out !== '0 || beat_cnt !== 4'd0 || weights_ready !== 1'b0) begin
      errors++; $display("FAIL async_reset got w=%h cnt=%0d rdy=%b want 0 0 0", w_out, beat_cnt, weights_ready);
    end
    tick(); rst_n = 1'b1;
    start = 1'b1; data_in = 16'h2222; tick(); tick(); start = 1'b0;
    checks++;
    if (mult_en !== 1'b0 || weights_ready !== 1'b0 || vec_out !== 16'h0000) begin
      errors++; $display("FAIL post_reset_start got en=%b rdy=%b v=%h want 0 0 0000", mult_en, weights_ready, vec_out);
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_load_gaps();
    test_bad_code();
    test_run();
    test_priority();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
